// File: rtl/fpu_cfg_pkg.sv
// Shared types and constants for the FPU config loader: word map, FSM states
// and the shadow/committed configuration record.
package fpu_cfg_pkg;

    localparam int unsigned NUM_CFG_WORDS = 6;

    localparam logic [2:0] CFG_W_SIZE   = 3'd0;
    localparam logic [2:0] CFG_W_START  = 3'd1;
    localparam logic [2:0] CFG_W_RESULT = 3'd2;
    localparam logic [2:0] CFG_W_FILT0  = 3'd3;
    localparam logic [2:0] CFG_W_FILT1  = 3'd4;
    localparam logic [2:0] CFG_W_FILT2  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } cfg_state_t;

    typedef struct packed {
        logic [8:0][7:0] filter;
        logic [31:0]     result_address;
        logic [31:0]     start_address;
        logic [15:0]     height;
        logic [15:0]     width;
    } cfg_shadow_t;

    function automatic logic cfg_invalid(input cfg_shadow_t s, input logic [15:0] max_w);
        return (s.width == '0) || (s.height == '0) || (s.width > max_w);
    endfunction

endpackage

// File: rtl/fpu_config_if.sv
// Config handshake between the loader, the config memory and the FPU datapath.
interface FPUConfig_if;
    logic            load_config_start;
    logic            mapped_data_valid;
    logic [31:0]     data_mem;
    logic            load_config_done;
    logic [8:0][7:0] filter;
    logic [15:0]     image_width;
    logic [15:0]     image_height;
    logic [31:0]     start_address;
    logic [31:0]     result_address;
    logic [31:0]     address_mem;

    modport Loader (
        input  load_config_start, mapped_data_valid, data_mem,
        output load_config_done, filter, image_width, image_height,
               start_address, result_address, address_mem
    );
endinterface

// File: rtl/fpu_config_loader.sv
// Walks the six config words into shadow registers, validates them and commits
// the whole set to the FPU-facing outputs in a single edge.
module fpu_config_loader
    import fpu_cfg_pkg::*;
#(
    parameter logic [31:0] CFG_BASE   = 32'h0000_1000,
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [15:0] MAX_WIDTH  = 16'd1920
) (
    input  logic         clk,
    input  logic         rst_n,
    FPUConfig_if.Loader  cfg,
    output logic         cfg_error
);

    cfg_state_t  r_state;
    cfg_state_t  w_state_next;
    logic [2:0]  r_idx;
    cfg_shadow_t r_shadow;
    cfg_shadow_t w_shadow_next;
    cfg_shadow_t r_active;
    logic        r_cfg_error;
    logic        w_capture;
    logic        w_last;
    logic        w_enter_load;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: if (cfg.load_config_start) w_state_next = LOAD;
            LOAD: begin
                if (cfg.mapped_data_valid) begin
                    w_capture = 1'b1;
                    if (r_idx == CFG_W_FILT2) begin
                        w_last       = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            DONE: if (cfg.load_config_start) w_state_next = LOAD;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_load = (r_state != LOAD) && (w_state_next == LOAD);

    // Merge the word being accepted so the final capture can be validated and
    // committed in the same edge it arrives.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_capture) begin
            case (r_idx)
                CFG_W_SIZE: begin
                    w_shadow_next.width  = cfg.data_mem[15:0];
                    w_shadow_next.height = cfg.data_mem[31:16];
                end
                CFG_W_START:  w_shadow_next.start_address  = cfg.data_mem;
                CFG_W_RESULT: w_shadow_next.result_address = cfg.data_mem;
                CFG_W_FILT0:  w_shadow_next.filter[3:0]    = cfg.data_mem;
                CFG_W_FILT1:  w_shadow_next.filter[7:4]    = cfg.data_mem;
                CFG_W_FILT2:  w_shadow_next.filter[8]      = cfg.data_mem[7:0];
                default:      w_shadow_next = r_shadow;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_load) begin
                r_idx <= '0;
            end else if (w_capture) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_cfg_error <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_enter_load) begin
                r_cfg_error <= 1'b0;
            end else if (w_last) begin
                if (cfg_invalid(w_shadow_next, MAX_WIDTH)) begin
                    r_cfg_error <= 1'b1;
                end else begin
                    r_active    <= w_shadow_next;
                    r_cfg_error <= 1'b0;
                end
            end
        end
    end

    assign cfg.address_mem      = (r_state == LOAD) ? (CFG_BASE + 32'(WORD_BYTES) * 32'(r_idx)) : '0;
    assign cfg.load_config_done = (r_state == DONE);
    assign cfg.image_width      = r_active.width;
    assign cfg.image_height     = r_active.height;
    assign cfg.start_address    = r_active.start_address;
    assign cfg.result_address   = r_active.result_address;
    assign cfg.filter           = r_active.filter;
    assign cfg_error            = r_cfg_error;

endmodule

// File: tb/tb_fpu_config_loader.sv
// Self-checking bench for fpu_config_loader: table vectors, corner sequences
// and randomized loads against a word-map reference model.
module tb_fpu_config_loader;

    logic clk;
    logic rst_n;
    logic cfg_error;

    FPUConfig_if u_if ();

    fpu_config_loader #(
        .CFG_BASE   (32'h0000_1000),
        .WORD_BYTES (4),
        .MAX_WIDTH  (16'd1920)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (u_if),
        .cfg_error (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [6];

    // Config memory responder: returns the word the loader is addressing.
    always_comb begin
        logic [31:0] off;
        off = u_if.address_mem - 32'h0000_1000;
        u_if.data_mem = 32'hDEAD_BEEF;
        if (off[1:0] == 2'b00 && (off >> 2) < 6) u_if.data_mem = mem[off >> 2];
    end

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_w, exp_h;
    logic [31:0] exp_s, exp_r;
    logic [7:0]  exp_f [9];
    logic        exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_w = 0; exp_h = 0; exp_s = 0; exp_r = 0; exp_err = 0;
        for (int i = 0; i < 9; i++) exp_f[i] = 0;
    endtask

    task automatic model_load();
        int unsigned w, h;
        w = mem[0] % 65536;
        h = mem[0] / 65536;
        exp_err = (w == 0) || (h == 0) || (w > 1920);
        if (!exp_err) begin
            exp_w = 16'(w);
            exp_h = 16'(h);
            exp_s = mem[1];
            exp_r = mem[2];
            for (int i = 0; i < 9; i++) exp_f[i] = 8'((mem[3 + i / 4] >> (8 * (i % 4))) & 255);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".width"},  32'(u_if.image_width),  32'(exp_w));
        chk({tag, ".height"}, 32'(u_if.image_height), 32'(exp_h));
        chk({tag, ".start"},  u_if.start_address,     exp_s);
        chk({tag, ".result"}, u_if.result_address,    exp_r);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s.filter%0d", tag, i), 32'(u_if.filter[i]), 32'(exp_f[i]));
        chk({tag, ".cfg_error"}, 32'(cfg_error), 32'(exp_err));
    endtask

    // mode 0: valid every cycle, 1: valid every 3rd cycle, 2: random valid.
    task automatic run_load(input string tag, input int mode, input bit pulse_mid,
                            input bit started, input int exp_cycles);
        int n, c;
        logic v;
        if (!started) begin
            u_if.load_config_start = 1'b1;
            @(negedge clk);
            u_if.load_config_start = 1'b0;
        end
        n = 0;
        c = 0;
        while (n < 6 && c < 200) begin
            c++;
            chk($sformatf("%s.addr_c%0d", tag, c), u_if.address_mem, 32'h1000 + 32'(4 * n));
            chk($sformatf("%s.done_low_c%0d", tag, c), 32'(u_if.load_config_done), 32'd0);
            if (c == 1) chk({tag, ".err_cleared"}, 32'(cfg_error), 32'd0);
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 3 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            u_if.mapped_data_valid = v;
            u_if.load_config_start = pulse_mid && (c == 2);
            @(negedge clk);
            if (v) n++;
        end
        u_if.mapped_data_valid = 1'b0;
        u_if.load_config_start = 1'b0;
        if (n < 6) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=%0d words required=6", tag, n);
        end
        chk({tag, ".done"}, 32'(u_if.load_config_done), 32'd1);
        chk({tag, ".addr_done"}, u_if.address_mem, 32'd0);
        if (exp_cycles > 0) chk({tag, ".cycles"}, 32'(c), 32'(exp_cycles));
        model_load();
        check_outputs(tag);
    endtask

    task automatic set_nominal();
        mem[0] = 32'h0078_00A0;
        mem[1] = 32'h0002_0000;
        mem[2] = 32'h0004_0000;
        mem[3] = 32'h0403_0201;
        mem[4] = 32'h0807_0605;
        mem[5] = 32'h0000_0009;
    endtask

    typedef struct {
        logic [31:0] word0;
        logic        exp_err;
        logic [15:0] exp_w;
        logic [15:0] exp_h;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{32'h0001_0780, 1'b0, 16'd1920, 16'd1};
        tbl[1] = '{32'h0001_0781, 1'b1, 16'd1920, 16'd1};
        tbl[2] = '{32'h0000_0010, 1'b1, 16'd1920, 16'd1};
        tbl[3] = '{32'h0005_0000, 1'b1, 16'd1920, 16'd1};
        tbl[4] = '{32'h0001_0001, 1'b0, 16'd1,    16'd1};
        tbl[5] = '{32'hFFFF_FFFF, 1'b1, 16'd1,    16'd1};
        tbl[6] = '{32'hFFFF_0780, 1'b0, 16'd1920, 16'd65535};

        rst_n = 1'b0;
        u_if.load_config_start = 1'b0;
        u_if.mapped_data_valid = 1'b0;
        for (int i = 0; i < 6; i++) mem[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.addr", u_if.address_mem, 32'd0);
        chk("reset.done", 32'(u_if.load_config_done), 32'd0);
        check_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Valid presented while idle must not advance anything.
        u_if.mapped_data_valid = 1'b1;
        @(negedge clk);
        u_if.mapped_data_valid = 1'b0;
        chk("idle_valid.addr", u_if.address_mem, 32'd0);
        chk("idle_valid.done", 32'(u_if.load_config_done), 32'd0);

        set_nominal();
        run_load("nominal", 0, 1'b0, 1'b0, 6);
        chk("nominal.width_abs", 32'(u_if.image_width), 32'd160);
        chk("nominal.height_abs", 32'(u_if.image_height), 32'd120);

        run_load("stalled", 1, 1'b0, 1'b0, 18);

        mem[0] = 32'h0078_0000;
        run_load("bad", 0, 1'b0, 1'b0, 6);
        chk("bad.err_abs", 32'(cfg_error), 32'd1);
        chk("bad.width_abs", 32'(u_if.image_width), 32'd160);

        set_nominal();
        run_load("renominal", 0, 1'b0, 1'b0, 6);
        for (int i = 0; i < 7; i++) begin
            mem[0] = tbl[i].word0;
            run_load($sformatf("tbl%0d", i), 0, 1'b0, 1'b0, 6);
            chk($sformatf("tbl%0d.err", i), 32'(cfg_error), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d.w", i), 32'(u_if.image_width), 32'(tbl[i].exp_w));
            chk($sformatf("tbl%0d.h", i), 32'(u_if.image_height), 32'(tbl[i].exp_h));
        end

        set_nominal();
        run_load("start_in_load", 0, 1'b1, 1'b0, 6);

        // Restart directly from DONE.
        u_if.load_config_start = 1'b1;
        @(negedge clk);
        u_if.load_config_start = 1'b0;
        chk("restart.done", 32'(u_if.load_config_done), 32'd0);
        chk("restart.addr", u_if.address_mem, 32'h1000);
        mem[1] = 32'h1234_5678;
        run_load("restart", 0, 1'b0, 1'b1, 6);

        // Reset after three words captured.
        u_if.load_config_start = 1'b1;
        @(negedge clk);
        u_if.load_config_start = 1'b0;
        u_if.mapped_data_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset.addr_before", u_if.address_mem, 32'h100C);
        u_if.mapped_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset.addr", u_if.address_mem, 32'd0);
        chk("midreset.done", 32'(u_if.load_config_done), 32'd0);
        check_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_nominal();
        run_load("after_reset", 0, 1'b0, 1'b0, 6);

        for (int t = 0; t < 20; t++) begin
            int unsigned w, h;
            w = $urandom_range(0, 2100);
            h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535);
            mem[0] = (h << 16) | w;
            for (int i = 1; i < 6; i++) mem[i] = $urandom;
            run_load($sformatf("rand%0d", t), 2, ($urandom_range(0, 3) == 0), 1'b0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
